// File: rtl/btb_fill_ctrl_if.sv
// BTB write port: the fill controller presents one queued entry per cycle, the BTB
// accepts it with btb_wr_ready.
interface btb_fill_ctrl_if;
    logic        btb_wr_valid;
    logic        btb_wr_ready;
    logic        BTBWriteD;
    logic [31:0] pcD;
    logic [31:0] branchimmD;
    logic [2:0]  funct3D;

    modport master (
        output btb_wr_valid,
        output BTBWriteD,
        output pcD,
        output branchimmD,
        output funct3D,
        input  btb_wr_ready
    );

    modport slave (
        input  btb_wr_valid,
        input  BTBWriteD,
        input  pcD,
        input  branchimmD,
        input  funct3D,
        output btb_wr_ready
    );
endinterface

// File: rtl/btb_fill_ctrl.sv
// Decode-side BTB writer: checks the fetch-time BTB prediction against the decoded
// instruction, raises redirects and queues fills into a small FIFO that drains to the BTB.
module btb_fill_ctrl #(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stallD,
    input  logic                     flushD,
    input  logic                     validF,
    input  logic [31:0]              pcF,
    input  logic                     BTBHit,
    input  logic [31:0]              branchimmF,
    input  logic [31:0]              instrD,
    output logic                     redirectD,
    output logic [31:0]              redirect_pc,
    btb_fill_ctrl_if.master          wr,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
    } entry_t;

    logic        valid_q;
    logic [31:0] pc_q;
    logic        hit_q;
    logic [31:0] imm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            hit_q   <= 1'b0;
            imm_q   <= '0;
        end else if (!stallD) begin
            if (flushD) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= validF;
                pc_q    <= pcF;
                hit_q   <= BTBHit;
                imm_q   <= branchimmF;
            end
        end
    end

    logic [6:0]  opcode;
    logic        is_br;
    logic        is_jal;
    logic        ctl;
    logic [31:0] dec_imm;
    logic [2:0]  dec_f3;
    logic        ev;
    logic        mismatch;
    logic        fill_req;

    assign opcode = instrD[6:0];
    assign is_br  = (opcode == OpBranch);
    assign is_jal = (opcode == OpJal);
    assign ctl    = is_br | is_jal;

    always_comb begin
        dec_imm = '0;
        dec_f3  = 3'b000;
        if (is_br) begin
            dec_imm = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            dec_f3  = instrD[14:12];
        end else if (is_jal) begin
            dec_imm = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                       instrD[30:21], 1'b0};
            dec_f3  = 3'b010;
        end
    end

    // An instruction is judged only on the cycle it leaves decode, so stalls never re-fire it.
    assign ev       = valid_q & ~stallD;
    assign mismatch = (imm_q != dec_imm);
    assign fill_req = ev & ctl & (~hit_q | mismatch);

    always_comb begin
        redirectD   = 1'b0;
        redirect_pc = '0;
        if (ev && !ctl && hit_q) begin
            redirectD   = 1'b1;
            redirect_pc = pc_q + 32'd4;
        end else if (ev && ctl && hit_q && mismatch) begin
            redirectD   = 1'b1;
            redirect_pc = pc_q + dec_imm;
        end
    end

    entry_t        mem [QDEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [DROP_W-1:0] drop_q;
    logic          not_empty;
    logic          full;
    logic          deq;
    logic          enq;
    logic          drop;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(QDEPTH));
    assign deq       = not_empty & wr.btb_wr_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq       = fill_req & (~full | deq);
    assign drop      = fill_req & full & ~deq;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail_q] <= '{pc: pc_q, imm: dec_imm, f3: dec_f3};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            if (enq) tail_q <= tail_q + AW'(1);
            if (deq) head_q <= head_q + AW'(1);
            if (enq && !deq)      count_q <= count_q + CW'(1);
            else if (deq && !enq) count_q <= count_q - CW'(1);
            if (drop && drop_q != '1) drop_q <= drop_q + DROP_W'(1);
        end
    end

    always_comb begin
        wr.btb_wr_valid = not_empty;
        wr.BTBWriteD    = deq;
        wr.pcD          = '0;
        wr.branchimmD   = '0;
        wr.funct3D      = '0;
        if (not_empty) begin
            wr.pcD        = mem[head_q].pc;
            wr.branchimmD = mem[head_q].imm;
            wr.funct3D    = mem[head_q].f3;
        end
    end

    assign q_count  = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_btb_fill_ctrl.sv
// Bench for btb_fill_ctrl: vector table for single-instruction checks, hand sequences for
// queue-full, stall/flush and asynchronous reset; BTB writes are checked against a scoreboard.
module tb_btb_fill_ctrl;
    localparam int unsigned QDEPTH = 2;
    localparam int unsigned DROP_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallD = 1'b0, flushD = 1'b0, validF = 1'b0, BTBHit = 1'b0;
    logic [31:0] pcF = '0, branchimmF = '0, instrD = NOP;
    logic        redirectD;
    logic [31:0] redirect_pc;
    logic [$clog2(QDEPTH):0] q_count;
    logic [DROP_W-1:0]       drop_cnt;

    always #5 clk = ~clk;

    btb_fill_ctrl_if wr();

    btb_fill_ctrl #(.QDEPTH(QDEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .stallD(stallD), .flushD(flushD), .validF(validF),
        .pcF(pcF), .BTBHit(BTBHit), .branchimmF(branchimmF), .instrD(instrD),
        .redirectD(redirectD), .redirect_pc(redirect_pc), .wr(wr),
        .q_count(q_count), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  f3;
    } ent_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] immf;
        logic [31:0] instr;
        logic        redir;
        logic [31:0] rpc;
        logic        enq;
        logic [31:0] imm;
        logic [2:0]  f3;
    } vec_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && wr.BTBWriteD) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got pc 0x%08h expected no write", wr.pcD);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("wr_pc", wr.pcD, e.pc);
                chk("wr_imm", wr.branchimmD, e.imm);
                chk("wr_f3", 32'(wr.funct3D), 32'(e.f3));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    vec_t vec [11];

    initial begin
        vec[0]  = '{1'b1, 32'h100, 1'b0, 32'h0, BEQ16, 1'b0, 32'h0, 1'b1, 32'h10, 3'd0};
        vec[1]  = '{1'b1, 32'h200, 1'b1, 32'h8, 32'h0010_0093, 1'b1, 32'h204, 1'b0, 32'h0, 3'd0};
        vec[2]  = '{1'b1, 32'h300, 1'b1, 32'h8, 32'hFFDF_F06F, 1'b1, 32'h2FC, 1'b1,
                    32'hFFFF_FFFC, 3'd2};
        vec[3]  = '{1'b1, 32'h400, 1'b1, 32'h10, 32'h0020_C463, 1'b1, 32'h408, 1'b1, 32'h8, 3'd4};
        vec[4]  = '{1'b1, 32'hFFFF_FFF0, 1'b1, 32'h0, BEQ16, 1'b1, 32'h0, 1'b1, 32'h10, 3'd0};
        vec[5]  = '{1'b1, 32'h1000, 1'b0, 32'h0, 32'h8000_5063, 1'b0, 32'h0, 1'b1,
                    32'hFFFF_F000, 3'd5};
        vec[6]  = '{1'b1, 32'h500, 1'b1, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0, 32'h0, 1'b0,
                    32'h0, 3'd0};
        vec[7]  = '{1'b1, 32'h600, 1'b0, 32'h0, 32'h0000_A083, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[8]  = '{1'b0, 32'h700, 1'b1, 32'h0, 32'h0010_0093, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[9]  = '{1'b1, 32'h104, 1'b1, 32'h10, BEQ16, 1'b0, 32'h0, 1'b0, 32'h0, 3'd0};
        vec[10] = '{1'b1, 32'h900, 1'b0, 32'h0, 32'hFFDF_F06F, 1'b0, 32'h0, 1'b1,
                    32'hFFFF_FFFC, 3'd2};

        wr.btb_wr_ready = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_redirect", 32'(redirectD), 32'h0);
        chk("rst_wr_valid", 32'(wr.btb_wr_valid), 32'h0);
        chk("rst_q_count", 32'(q_count), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_pcD", wr.pcD, 32'h0);
        reset = 1'b1;
        next_cycle();

        // Single-instruction vectors with the BTB always ready.
        wr.btb_wr_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            validF = vec[i].valid; pcF = vec[i].pc; BTBHit = vec[i].hit;
            branchimmF = vec[i].immf; instrD = NOP;
            next_cycle();
            validF = 1'b0; BTBHit = 1'b0; instrD = vec[i].instr;
            @(negedge clk);
            chk($sformatf("v%0d_redirect", i), 32'(redirectD), 32'(vec[i].redir));
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vec[i].rpc);
            if (vec[i].enq) sb.push_back('{vec[i].pc, vec[i].imm, vec[i].f3});
            next_cycle();
            instrD = NOP;
            @(negedge clk);
            chk($sformatf("v%0d_wr_valid", i), 32'(wr.btb_wr_valid), 32'(vec[i].enq));
            next_cycle();
        end

        // Full queue: third miss dropped, fourth accepted alongside a dequeue.
        wr.btb_wr_ready = 1'b0;
        instrD = BEQ16; BTBHit = 1'b0;
        validF = 1'b1; pcF = 32'h600; next_cycle();
        pcF = 32'h604; next_cycle();
        pcF = 32'h608; next_cycle();
        validF = 1'b0; next_cycle();
        sb.push_back('{32'h600, 32'h10, 3'd0});
        sb.push_back('{32'h604, 32'h10, 3'd0});
        @(negedge clk);
        chk("full_q_count", 32'(q_count), 32'd2);
        chk("full_drop_cnt", 32'(drop_cnt), 32'd1);
        validF = 1'b1; pcF = 32'h60C; next_cycle();
        validF = 1'b0; wr.btb_wr_ready = 1'b1;
        sb.push_back('{32'h60C, 32'h10, 3'd0});
        next_cycle();
        @(negedge clk);
        chk("fulldeq_q_count", 32'(q_count), 32'd2);
        chk("fulldeq_drop_cnt", 32'(drop_cnt), 32'd1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("drained_q_count", 32'(q_count), 32'd0);

        // Stall holds the miss in decode; it is queued once, on release.
        wr.btb_wr_ready = 1'b0;
        validF = 1'b1; pcF = 32'h700; next_cycle();
        validF = 1'b0; stallD = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_q_count", c), 32'(q_count), 32'd0);
            next_cycle();
        end
        stallD = 1'b0; next_cycle();
        sb.push_back('{32'h700, 32'h10, 3'd0});
        @(negedge clk);
        chk("release_q_count", 32'(q_count), 32'd1);
        validF = 1'b1; pcF = 32'h704; flushD = 1'b1; next_cycle();
        validF = 1'b0; flushD = 1'b0; next_cycle();
        next_cycle();
        @(negedge clk);
        chk("flush_q_count", 32'(q_count), 32'd1);
        wr.btb_wr_ready = 1'b1; next_cycle();
        @(negedge clk);
        chk("stall_drained", 32'(q_count), 32'd0);

        // Asynchronous reset mid-cycle with two entries waiting.
        wr.btb_wr_ready = 1'b0;
        validF = 1'b1; pcF = 32'h800; next_cycle();
        pcF = 32'h804; next_cycle();
        validF = 1'b0; next_cycle();
        @(negedge clk);
        chk("prerst_q_count", 32'(q_count), 32'd2);
        chk("prerst_pcD", wr.pcD, 32'h800);
        next_cycle();
        #2 reset = 1'b0;
        wr.btb_wr_ready = 1'b1;
        #1;
        chk("arst_wr_valid", 32'(wr.btb_wr_valid), 32'h0);
        chk("arst_q_count", 32'(q_count), 32'h0);
        chk("arst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("arst_pcD", wr.pcD, 32'h0);
        instrD = NOP;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        @(negedge clk);
        chk("postrst_q_count", 32'(q_count), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
